// File: rtl/lms_mu_sched.sv
// lms_mu_sched: adaptation controller for the 16-tap LMS noise canceller.
// It generates the sample-rate en strobe and keeps a leaky average of |err|.
// That average selects the LMS step-size shift u: a fast step while acquiring
// and a slow step once the filter has converged.
module lms_mu_sched #(
  parameter int E_W     = 16,
  parameter int DIV_W   = 16,
  parameter int CNT_W   = 16,
  parameter int ACC_SH  = 4,
  parameter int MU_FAST = 4,
  parameter int MU_SLOW = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  stop,
  input  logic [DIV_W-1:0]      sample_div,
  input  logic [E_W-1:0]        thr_lo,
  input  logic [E_W-1:0]        thr_hi,
  input  logic [CNT_W-1:0]      settle_cnt,
  input  logic                  update,
  input  logic signed [E_W-1:0] err,
  output logic                  en,
  output logic [7:0]            u,
  output logic [1:0]            state,
  output logic [E_W-1:0]        err_mag,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACQ   = 2'd1,
    TRACK = 2'd2
  } state_t;

  state_t           state_q;
  logic             en_q;
  logic [7:0]       u_q;
  logic [E_W-1:0]   err_mag_q;
  logic             busy_q;
  logic [DIV_W-1:0] cnt_q;
  logic [CNT_W-1:0] settle_q;

  logic [E_W-1:0]   err_mag_d;
  logic [CNT_W:0]   settle_inc_d;
  logic [CNT_W:0]   settle_tgt_d;
  logic [DIV_W-1:0] div_eff_d;

  // |x| with the most negative code clipped to the largest positive value.
  function automatic logic [E_W-1:0] abs_sat(input logic signed [E_W-1:0] x);
    logic signed [E_W-1:0] most_neg;
    most_neg = {1'b1, {(E_W-1){1'b0}}};
    if (x == most_neg)
      abs_sat = {1'b0, {(E_W-1){1'b1}}};
    else if (x[E_W-1])
      abs_sat = $unsigned(-x);
    else
      abs_sat = $unsigned(x);
  endfunction

  // One leak step. Both operands stay below 2^(E_W-1), so the result fits
  // in E_W bits without wrapping.
  function automatic logic [E_W-1:0] leak_avg(input logic [E_W-1:0] m,
                                               input logic [E_W-1:0] a);
    leak_avg = m - (m >> ACC_SH) + (a >> ACC_SH);
  endfunction

  // Candidate average, settle bookkeeping and clamped divider, all for this cycle.
  always_comb begin
    err_mag_d    = leak_avg(err_mag_q, abs_sat(err));
    settle_inc_d = {1'b0, settle_q} + {{CNT_W{1'b0}}, 1'b1};
    settle_tgt_d = {1'b0, (settle_cnt == '0) ? CNT_W'(1) : settle_cnt};
    div_eff_d    = (sample_div == '0) ? DIV_W'(1) : sample_div;
  end

  // Mode FSM with registered en/u/busy outputs. Priority: stop, start, update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      en_q      <= 1'b0;
      u_q       <= 8'(MU_SLOW);
      err_mag_q <= '0;
      busy_q    <= 1'b0;
      cnt_q     <= '0;
      settle_q  <= '0;
    end else if (stop) begin
      state_q <= IDLE;
      en_q    <= 1'b0;
      u_q     <= 8'(MU_SLOW);
      busy_q  <= 1'b0;
    end else if (start) begin
      // A zeroed counter fires en on the very next edge and restarts the phase.
      state_q   <= ACQ;
      en_q      <= 1'b0;
      u_q       <= 8'(MU_FAST);
      busy_q    <= 1'b1;
      err_mag_q <= '0;
      cnt_q     <= '0;
      settle_q  <= '0;
    end else if (state_q != IDLE) begin
      // The period is reloaded on each wrap, so divider changes apply at the next pulse.
      en_q  <= (cnt_q == '0);
      cnt_q <= (cnt_q == '0) ? div_eff_d : cnt_q - 1'b1;
      if (update) begin
        err_mag_q <= err_mag_d;
        if (state_q == ACQ) begin
          if (err_mag_d < thr_lo) begin
            if (settle_inc_d >= settle_tgt_d) begin
              state_q  <= TRACK;
              u_q      <= 8'(MU_SLOW);
              settle_q <= '0;
            end else begin
              settle_q <= settle_inc_d[CNT_W-1:0];
            end
          end else begin
            settle_q <= '0;
          end
        end else if (err_mag_d > thr_hi) begin
          state_q  <= ACQ;
          u_q      <= 8'(MU_FAST);
          settle_q <= '0;
        end
      end
    end
  end

  assign en      = en_q;
  assign u       = u_q;
  assign state   = state_q;
  assign err_mag = err_mag_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_lms_mu_sched.sv
// Directed and randomized bench for lms_mu_sched, checked against a
// cycle-level behavioural model of the adaptation rules.
module tb_lms_mu_sched;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0;
  logic               stop = 1'b0;
  logic               update = 1'b0;
  logic [15:0]        sample_div = 16'd0;
  logic [15:0]        thr_lo = 16'd0;
  logic [15:0]        thr_hi = 16'hFFFF;
  logic [15:0]        settle_cnt = 16'd1;
  logic signed [15:0] err = 16'sd0;
  logic               en;
  logic [7:0]         u;
  logic [1:0]         state;
  logic [15:0]        err_mag;
  logic               busy;

  int total = 0;
  int bad = 0;

  // Model state: mode 0/1/2, average, settle count, cycle index of next en.
  int cyc = 0;
  int m_state = 0;
  int m_mag = 0;
  int m_settle = 0;
  int next_en = 0;
  bit exp_en = 1'b0;

  always #5 clk = ~clk;

  lms_mu_sched dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .sample_div(sample_div), .thr_lo(thr_lo), .thr_hi(thr_hi),
    .settle_cnt(settle_cnt), .update(update), .err(err),
    .en(en), .u(u), .state(state), .err_mag(err_mag), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".en"}, {31'd0, en}, {31'd0, exp_en});
    chk({tag, ".state"}, {30'd0, state}, m_state);
    chk({tag, ".u"}, {24'd0, u}, (m_state == 1) ? 4 : 10);
    chk({tag, ".err_mag"}, {16'd0, err_mag}, m_mag);
    chk({tag, ".busy"}, {31'd0, busy}, (m_state != 0) ? 1 : 0);
  endtask

  // One clock: drive at negedge, sample 1 time unit after posedge, advance model.
  task automatic tick(input bit st, input bit sp, input bit up, input int e, input string tag);
    int a;
    int mn;
    int tgt;
    @(negedge clk);
    start = st; stop = sp; update = up; err = 16'(e);
    @(posedge clk);
    #1;
    cyc++;
    if (sp) begin
      m_state = 0; exp_en = 1'b0;
    end else if (st) begin
      m_state = 1; m_mag = 0; m_settle = 0; next_en = cyc + 1; exp_en = 1'b0;
    end else if (m_state == 0) begin
      exp_en = 1'b0;
    end else begin
      exp_en = (cyc == next_en);
      if (exp_en) next_en = cyc + ((sample_div == 0) ? 1 : int'(sample_div)) + 1;
      if (up) begin
        a = (e == -32768) ? 32767 : ((e < 0) ? -e : e);
        mn = m_mag - m_mag / 16 + a / 16;
        tgt = (settle_cnt == 0) ? 1 : int'(settle_cnt);
        if (m_state == 1) begin
          if (mn < int'(thr_lo)) begin
            m_settle++;
            if (m_settle >= tgt) begin m_state = 2; m_settle = 0; end
          end else begin
            m_settle = 0;
          end
        end else if (mn > int'(thr_hi)) begin
          m_state = 1; m_settle = 0;
        end
        m_mag = mn;
      end
    end
    chk_all(tag);
    start = 1'b0; stop = 1'b0; update = 1'b0;
  endtask

  task automatic run(input int n, input string tag);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0, 0, tag);
  endtask

  initial begin
    // Reset held across two edges, then released.
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Idle: nothing moves, update ignored.
    run(100, "idle");
    tick(1'b0, 1'b0, 1'b1, 1000, "idle_upd");
    chk("idle_upd_mag", {16'd0, err_mag}, 0);

    // Period 10: en at k+1, k+11, k+21.
    sample_div = 16'd9;
    tick(1'b1, 1'b0, 1'b0, 0, "start9");
    chk("start9_u", {24'd0, u}, 4);
    chk("start9_state", {30'd0, state}, 1);
    tick(1'b0, 1'b0, 1'b0, 0, "en9_k1");
    chk("en9_k1_pulse", {31'd0, en}, 1);
    run(9, "en9_gap");
    tick(1'b0, 1'b0, 1'b0, 0, "en9_k11");
    chk("en9_k11_pulse", {31'd0, en}, 1);
    run(10, "en9_k21");
    chk("en9_k21_pulse", {31'd0, en}, 1);
    run(4, "en9_tail");

    // Divider 0 clamps to period 2.
    sample_div = 16'd0;
    tick(1'b1, 1'b0, 1'b0, 0, "start0");
    run(8, "en0");

    // Most negative error saturates: first update from 0 gives 2047.
    thr_lo = 16'd0; thr_hi = 16'hFFFF;
    sample_div = 16'd3;
    tick(1'b1, 1'b0, 1'b0, 0, "sat_start");
    tick(1'b0, 1'b0, 1'b1, -32768, "sat1");
    chk("sat_first", {16'd0, err_mag}, 2047);
    for (int i = 0; i < 60; i++) tick(1'b0, 1'b0, (i % 2) == 0, -32768, "sat_run");

    // Convergence after 3 below-threshold updates, with a count reset in between.
    thr_lo = 16'd100; settle_cnt = 16'd3;
    tick(1'b1, 1'b0, 1'b0, 0, "conv_start");
    tick(1'b0, 1'b0, 1'b1, 0, "conv_b1");
    tick(1'b0, 1'b0, 1'b1, 0, "conv_b2");
    thr_lo = 16'd0;
    tick(1'b0, 1'b0, 1'b1, 0, "conv_above");
    thr_lo = 16'd100;
    tick(1'b0, 1'b0, 1'b1, 0, "conv_b1b");
    tick(1'b0, 1'b0, 1'b1, 0, "conv_b2b");
    chk("conv_still_acq", {30'd0, state}, 1);
    tick(1'b0, 1'b0, 1'b1, 0, "conv_b3");
    chk("conv_track", {30'd0, state}, 2);
    chk("conv_u", {24'd0, u}, 10);
    run(3, "track_idle");

    // Divergence from TRACK.
    thr_hi = 16'd500;
    tick(1'b0, 1'b0, 1'b1, 20000, "div1");
    chk("div_acq", {30'd0, state}, 1);
    chk("div_u", {24'd0, u}, 4);
    tick(1'b0, 1'b0, 1'b1, 20000, "div2");

    // start while in TRACK restarts ACQ, the average and the en phase.
    thr_lo = 16'd30000; settle_cnt = 16'd1;
    tick(1'b0, 1'b0, 1'b1, 0, "to_track");
    run(2, "track2");
    tick(1'b1, 1'b0, 1'b1, 20000, "restart");
    chk("restart_mag", {16'd0, err_mag}, 0);
    run(6, "restart_en");

    // stop with update: average held. start+stop: IDLE.
    thr_lo = 16'd0; thr_hi = 16'hFFFF;
    tick(1'b0, 1'b0, 1'b1, 8000, "pre_stop");
    tick(1'b0, 1'b1, 1'b1, 30000, "stop_upd");
    run(3, "stopped");
    tick(1'b1, 1'b1, 1'b0, 0, "start_stop");
    chk("start_stop_state", {30'd0, state}, 0);

    // Randomized run with occasional restarts, stops and divider changes.
    for (int i = 0; i < 1500; i++) begin
      int r;
      int e;
      r = int'($urandom_range(0, 99));
      if ((i % 200) == 0) begin
        thr_lo = 16'($urandom_range(0, 3000));
        thr_hi = 16'($urandom_range(500, 6000));
        settle_cnt = 16'($urandom_range(0, 4));
      end
      if (r == 7) sample_div = 16'($urandom_range(0, 6));
      e = ($urandom_range(0, 15) == 0) ? -32768 : int'($urandom_range(0, 65535)) - 32768;
      if ((i % 4) == 1) e = e / 64;
      tick(r < 2, r == 99, r > 60, e, "rand");
    end

    // Asynchronous reset mid-run.
    tick(1'b1, 1'b0, 1'b0, 0, "pre_rst");
    tick(1'b0, 1'b0, 1'b1, 30000, "pre_rst_upd");
    tick(1'b0, 1'b0, 1'b0, 0, "pre_rst_idle");
    rst_n = 1'b0;
    #1;
    m_state = 0; m_mag = 0; m_settle = 0; exp_en = 1'b0;
    chk_all("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    run(5, "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lms_mu_sched.md
# lms_mu_sched

Adaptation controller for the 16-tap LMS noise canceller. It produces the sample-rate `en` strobe that drives the LMS filter and watches the filter's `err`/`update` outputs. It keeps a leaky average of |err| and uses it to schedule the step-size shift `u`: a large step while acquiring, a small step once converged, and a fall back to acquisition when the error grows. The block sits between the top-level control registers and the LMS instance.

## Interface
- `E_W`, 16: width of the LMS error.
- `DIV_W`, 16: width of the sample divider.
- `CNT_W`, 16: width of the settle counter.
- `ACC_SH`, 4: leak shift of the error-magnitude average (time constant 2^ACC_SH updates).
- `MU_FAST`, 4: `u` value used in ACQ.
- `MU_SLOW`, 10: `u` value used in IDLE and TRACK.
- `clk`  in  1  clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  pulse; (re)starts adaptation in ACQ.
- `stop`  in  1  pulse; returns to IDLE. Wins over `start` when both are high.
- `sample_div`  in  DIV_W  en period minus 1; values 0 and 1 are treated as 1.
- `thr_lo`  in  E_W  convergence threshold on `err_mag` (unsigned).
- `thr_hi`  in  E_W  divergence threshold on `err_mag` (unsigned).
- `settle_cnt`  in  CNT_W  consecutive below-threshold updates required to enter TRACK; 0 is treated as 1.
- `update`  in  1  one-cycle pulse from the LMS block; `err` is valid in the same cycle.
- `err`  in  E_W  signed LMS error.
- `en`  out  1  one-cycle sample strobe to the LMS block.
- `u`  out  8  step-size shift to the LMS block.
- `state`  out  2  0=IDLE, 1=ACQ, 2=TRACK.
- `err_mag`  out  E_W  unsigned leaky average of |err|.
- `busy`  out  1  high when state is not IDLE.

## Operation
- Reset values: state IDLE, `en`=0, `u`=MU_SLOW, `err_mag`=0, `busy`=0, sample counter 0, settle counter 0.
- IDLE
  - `en` stays low.
  - `update` is ignored.
  - `start` moves to ACQ, clears `err_mag`, the sample counter and the settle counter.
- ACQ and TRACK
  - The sample counter runs freely.
  - `en` pulses once every max(sample_div,1)+1 cycles.
- `start` while busy restarts the run exactly as it does from IDLE, including the `en` phase.
- `stop` from any state goes to IDLE; `en` is low from the next cycle on.
- Error magnitude:
  - `a` = |err|, with the most negative value saturated to 2^(E_W-1)-1.
  - Next magnitude `m'` = err_mag − (err_mag>>ACC_SH) + (a>>ACC_SH), computed unsigned with no overflow possible.
  - `err_mag` is loaded with `m'` only on an `update` cycle in ACQ or TRACK.
- ACQ → TRACK
  - On each `update`: if `m'` < thr_lo, increment the settle counter, otherwise clear it.
  - When the incremented count reaches max(settle_cnt,1), go to TRACK and clear the counter.
- TRACK → ACQ
  - Any `update` with `m'` > thr_hi moves to ACQ and clears the settle counter.
- `u` is registered: MU_FAST in ACQ, MU_SLOW in IDLE and TRACK. It changes on the same edge as the state.
- `sample_div` changes take effect at the next counter wrap.
- Thresholds are sampled on every `update`.

## Timing
- `start` sampled at edge k:
  - state, `busy` and `u` update at edge k.
  - The first `en` pulse occurs in cycle k+1 (registered output).
  - Subsequent pulses occur every P = max(sample_div,1)+1 cycles.
- `update` at edge j:
  - `err_mag`, the settle counter, `state` and `u` all update at edge j.
  - The decision uses `m'`, so there is no extra cycle of latency.
- `stop` at edge s: `en`=0 from cycle s+1. An LMS update already in flight is ignored.
- `stop` and `update` in the same cycle: `stop` wins and `err_mag` is held.
- `start` and `update` in the same cycle: restart wins and `err_mag` is cleared.
- Asynchronous reset mid-run: all outputs return to their reset values immediately.
- The LMS block needs P ≥ its compute latency. Meeting that is the integrator's responsibility; this block does not check it.

## Test plan
- Reset, then idle for 100 cycles: `en`=0, `u`=10, `state`=0, `err_mag`=0. Pulse `update` with err=1000: `err_mag` stays 0.
- `sample_div`=9, pulse `start`: `en` pulses in cycle k+1, k+11, k+21; `u`=4, `state`=1. Repeat with `sample_div`=0: period is 2.
- Constant err=−32768 on each update from `err_mag`=0: the first update gives `err_mag`=2047; saturation holds with no wrap.
- `thr_lo`=100, `settle_cnt`=3, err=0 from `err_mag`=0: TRACK and `u`=10 on the third update. A sequence of below, above, below updates resets the count.
- In TRACK with `thr_hi`=500, apply err=20000 repeatedly: return to ACQ (`u`=4) on the first update with `m'` > 500.
- Simultaneous `start`+`stop` gives IDLE. `start` while in TRACK gives ACQ with `err_mag`=0 and the `en` phase restarted. Asserting `rst_n` low mid-run immediately zeroes `en`, `busy` and `err_mag`.
